// File: rtl/conv_window_ctrl.sv
// Window sequencer for one 2x2 convolution neuron over a raster-scanned 8-bit image.
// Optional build macro CONV_CTRL_RELU_EN clamps negative neuron results to zero before the FIFO.
module conv_window_ctrl #(
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int NRN_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] kernel_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  pix_data,
  output logic [31:0] nrn_kernel,
  output logic [31:0] nrn_pixels,
  input  logic [7:0]  nrn_result,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_data,
  output logic        busy,
  output logic        done
);

  localparam int CLW = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PL  = NRN_LAT + 1;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CLW-1:0]  r_col;
  logic [RW-1:0]   r_row;
  logic [7:0]      r_line [IMG_W];
  logic [7:0]      r_prev;
  logic [7:0]      r_diag;
  logic [31:0]     r_kernel;
  logic [31:0]     r_pixels;
  logic [PL-1:0]   r_pipe;
  logic [7:0]      r_fifo [FIFO_DEPTH];
  logic [CW-1:0]   r_count;

  logic            w_accept;
  logic            w_last_col;
  logic            w_last_row;
  logic            w_issue;
  logic            w_push;
  logic            w_pop;
  logic            w_pipe_empty;
  logic            w_done;
  logic [7:0]      w_line_rd;
  logic [7:0]      w_wr_data;
  logic [CW:0]     w_inflight;
  logic [CW:0]     w_occ;
  logic [PL-1:0]   w_pipe_next;
  logic [7:0]      w_above [FIFO_DEPTH];
  int              w_wr_idx;

  assign w_accept     = pix_valid && pix_ready;
  assign w_last_col   = (r_col == CLW'(IMG_W - 1));
  assign w_last_row   = (r_row == RW'(IMG_H - 1));
  assign w_issue      = w_accept && (r_row != '0) && (r_col != '0);
  assign w_push       = r_pipe[PL-1];
  assign w_pop        = res_valid && res_ready;
  assign w_pipe_empty = (r_pipe == '0);
  assign w_line_rd    = r_line[r_col];
  assign w_wr_idx     = w_pop ? int'(r_count) - 1 : int'(r_count);

`ifdef CONV_CTRL_RELU_EN
  assign w_wr_data = nrn_result[7] ? 8'h00 : nrn_result;
`else
  assign w_wr_data = nrn_result;
`endif

  // Occupancy counts windows still in the neuron so the FIFO can never overflow.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < PL; i++) begin
      w_inflight = w_inflight + (CW+1)'(r_pipe[i]);
    end
    w_occ = (CW+1)'(r_count) + w_inflight;
  end

  assign pix_ready = (r_state == S_STREAM) && (w_occ < (CW+1)'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE:   if (start) w_state_next = S_STREAM;
      S_STREAM: if (w_accept && w_last_row && w_last_col) w_state_next = S_DRAIN;
      S_DRAIN: begin
        if (w_pipe_empty && (r_count == '0)) begin
          w_state_next = S_IDLE;
          w_done       = 1'b1;
        end
      end
      default:  w_state_next = S_IDLE;
    endcase
  end

  // r_diag trails the line buffer by one column, giving the top-left tap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kernel <= '0;
      r_pixels <= '0;
      r_prev   <= '0;
      r_diag   <= '0;
      r_col    <= '0;
      r_row    <= '0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_kernel <= kernel_in;
        r_col    <= '0;
        r_row    <= '0;
      end
      if (w_accept) begin
        r_prev <= pix_data;
        r_diag <= w_line_rd;
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        if (w_issue) r_pixels <= {r_diag, w_line_rd, r_prev, pix_data};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_line[r_col] <= pix_data;
  end

  genvar gi;
  generate
    for (gi = 0; gi < PL; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign w_pipe_next[gi] = w_issue;
      end else begin : g_tail
        assign w_pipe_next[gi] = r_pipe[gi-1];
      end
    end
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_above
      if (gi < FIFO_DEPTH - 1) begin : g_mid
        assign w_above[gi] = r_fifo[gi+1];
      end else begin : g_top
        assign w_above[gi] = 8'h00;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pipe <= '0;
    else        r_pipe <= w_pipe_next;
  end

  // Shift FIFO: entry 0 is the head and slots at or above r_count always hold zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= 8'h00;
      r_count <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (w_push && (i == w_wr_idx)) r_fifo[i] <= w_wr_data;
        else if (w_pop)                r_fifo[i] <= w_above[i];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign res_valid  = (r_count != '0);
  assign res_data   = r_fifo[0];
  assign nrn_kernel = r_kernel;
  assign nrn_pixels = r_pixels;
  assign busy       = (r_state != S_IDLE);
  assign done       = w_done;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Scoreboard bench for conv_window_ctrl with a registered 2x2 neuron model on a 4x3 image.
module tb_conv_window_ctrl;
  localparam int IMG_W = 4, IMG_H = 3, NRN_LAT = 1, FIFO_DEPTH = 4, NWIN = 6;
`ifdef CONV_CTRL_RELU_EN
  localparam logic [7:0] EXP_NEG = 8'h00;
`else
  localparam logic [7:0] EXP_NEG = 8'hfb;
`endif

  logic        clk, rst_n, start, pix_valid, pix_ready, res_valid, res_ready, busy, done;
  logic [31:0] kernel_in, nrn_kernel, nrn_pixels;
  logic [7:0]  pix_data, nrn_result, res_data;

  int          n_checks = 0, n_fail = 0;
  int          res_cnt = 0, done_cnt = 0, res_base = 0, done_base = 0;
  int          pr = 0, pc = 0;
  logic [7:0]  last_res;
  logic [7:0]  exp_q [$];
  logic [31:0] cur_kernel;
  logic [7:0]  img [IMG_H][IMG_W];
  logic        stop_rand;

  conv_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .NRN_LAT(NRN_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kernel_in(kernel_in),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .nrn_kernel(nrn_kernel), .nrn_pixels(nrn_pixels), .nrn_result(nrn_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] nrn_model(input logic [31:0] k, input logic [31:0] p);
    int s = 0;
    for (int i = 0; i < 4; i++) s += int'($signed(k[8*i +: 8])) * int'($signed(p[8*i +: 8]));
    return s[7:0];
  endfunction

  function automatic logic [7:0] exp_out(input logic [7:0] v);
`ifdef CONV_CTRL_RELU_EN
    return v[7] ? 8'h00 : v;
`else
    return v;
`endif
  endfunction

  always @(posedge clk) nrn_result <= nrn_model(nrn_kernel, nrn_pixels);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Result monitor: one pop per sampled valid&&ready.
  always @(negedge clk) begin
    #1;
    if (rst_n && done) done_cnt++;
    if (rst_n && res_valid && res_ready) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("res_data", 32'(res_data), 32'(exp_q.pop_front()));
      $display("result %0d: %h", res_cnt - res_base, res_data);
      last_res = res_data;
      res_cnt++;
    end
  end

  task automatic do_start(input logic [31:0] k);
    start = 1'b1; kernel_in = k;
    @(negedge clk);
    start = 1'b0;
    cur_kernel = k; pr = 0; pc = 0;
    res_base = res_cnt; done_base = done_cnt;
    check("kernel_latch", nrn_kernel, k);
    check("busy_stream", 32'(busy), 32'd1);
  endtask

  task automatic send_pix(input logic [7:0] p);
    int t = 0;
    logic [31:0] win;
    logic issued = 1'b0;
    pix_valid = 1'b1; pix_data = p;
    while (!pix_ready && t < 100) begin @(negedge clk); t++; end
    check("pix_ready_wait", 32'(pix_ready), 32'd1);
    if (!pix_ready) begin pix_valid = 1'b0; return; end
    @(posedge clk);
    img[pr][pc] = p;
    if (pr >= 1 && pc >= 1) begin
      win = {img[pr-1][pc-1], img[pr-1][pc], img[pr][pc-1], p};
      exp_q.push_back(exp_out(nrn_model(cur_kernel, win)));
      issued = 1'b1;
    end
    if (pc == IMG_W - 1) begin pc = 0; pr = (pr == IMG_H - 1) ? 0 : pr + 1; end
    else pc++;
    @(negedge clk);
    if (issued) check("nrn_pixels", nrn_pixels, win);
  endtask

  task automatic finish_frame();
    int t = 0;
    pix_valid = 1'b0;
    while (done_cnt == done_base && t < 300) begin @(negedge clk); t++; end
    check("done_seen", 32'(done_cnt != done_base), 32'd1);
    repeat (3) @(negedge clk);
    #2;
    check("done_once", 32'(done_cnt - done_base), 32'd1);
    check("busy_idle", 32'(busy), 32'd0);
    check("res_count", 32'(res_cnt - res_base), 32'(NWIN));
    check("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pix_ready"},  32'(pix_ready), 32'd0);
    check({tag, "_res_valid"},  32'(res_valid), 32'd0);
    check({tag, "_res_data"},   32'(res_data), 32'd0);
    check({tag, "_busy"},       32'(busy), 32'd0);
    check({tag, "_done"},       32'(done), 32'd0);
    check({tag, "_nrn_kernel"}, nrn_kernel, 32'd0);
    check({tag, "_nrn_pixels"}, nrn_pixels, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; kernel_in = '0; pix_valid = 1'b0; pix_data = '0;
    res_ready = 1'b1; stop_rand = 1'b0; cur_kernel = '0; last_res = '0;
    #3;
    check_reset_outputs("por");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Counting pixels, symmetric kernel.
    do_start(32'hfb0505fb);
    for (int i = 0; i < 12; i++) begin
      send_pix(8'(i));
      if (i == 5) check("first_window", nrn_pixels, 32'h00010405);
    end
    finish_frame();

    // Flat image cancels.
    do_start(32'h05fbfb05);
    for (int i = 0; i < 12; i++) send_pix(8'h01);
    finish_frame();
    check("flat_res", 32'(last_res), 32'h00);

    // Consumer stalled: flow control must stop at four outstanding windows.
    res_ready = 1'b0;
    do_start(32'h01020304);
    for (int i = 0; i < 10; i++) send_pix(8'(i * 3));
    pix_valid = 1'b1; pix_data = 8'd30;
    for (int k = 0; k < 6; k++) begin
      check("stall_pix_ready", 32'(pix_ready), 32'd0);
      @(negedge clk);
    end
    check("stall_res_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    send_pix(8'd30);
    send_pix(8'd33);
    finish_frame();

    // Asynchronous reset mid-frame.
    do_start(32'h02ff0103);
    for (int i = 0; i < 7; i++) send_pix(8'(i + 1));
    pix_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(32'h03fd02fe);
    for (int i = 0; i < 12; i++) send_pix(8'($urandom_range(0, 127)));
    finish_frame();

    // start during STREAM is ignored.
    do_start(32'h11223344);
    for (int i = 0; i < 5; i++) send_pix(8'(i + 10));
    pix_valid = 1'b0; start = 1'b1; kernel_in = 32'hdeadbeef;
    @(negedge clk);
    start = 1'b0;
    check("start_ignored_kernel", nrn_kernel, 32'h11223344);
    check("start_ignored_busy", 32'(busy), 32'd1);
    for (int i = 5; i < 12; i++) send_pix(8'(i + 10));
    finish_frame();

    // Negative result: clamped in the RELU build, passed through otherwise.
    do_start(32'hfb000000);
    for (int i = 0; i < 12; i++) send_pix(8'h01);
    finish_frame();
    check("neg_res", 32'(last_res), 32'(EXP_NEG));

    // Random kernel, pixels and consumer backpressure.
    fork
      begin
        do_start($urandom);
        for (int i = 0; i < 12; i++) send_pix(8'($urandom_range(0, 255)));
        finish_frame();
        stop_rand = 1'b1;
      end
      begin
        while (!stop_rand) begin
          @(negedge clk);
          res_ready = 1'($urandom_range(0, 1));
        end
        res_ready = 1'b1;
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
